// File: rtl/uart_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_pkg
// Brief    : Shared mode encodings, FSM state types and baud divisor helper
//            for the UART FIFO bridge.
// Revision : 1.0
// ============================================================================
package uart_fifo_pkg;

    localparam logic [1:0] MODE_LOOP  = 2'b00;
    localparam logic [1:0] MODE_HOST  = 2'b01;
    localparam logic [1:0] MODE_PACED = 2'b10;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_bridge_if
// Brief    : Valid-ready host write/read channels of the UART FIFO bridge.
// Revision : 1.0
// ============================================================================
interface uart_fifo_bridge_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output wdata, wvalid, rready,
        input  wready, rdata, rvalid
    );

    modport slave (
        input  wdata, wvalid, rready,
        output wready, rdata, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : First-word fall-through synchronous FIFO with fill count.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);
    localparam int unsigned         c_depth     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_depth_cnt = (ADDR_WIDTH + 1)'(c_depth);

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_push;
    logic                  w_pop;

    assign full   = (r_count == c_depth_cnt);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rptr];
    // A push while full is dropped even if a pop frees a slot this cycle.
    assign w_push = we && !full;
    assign w_pop  = re && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_bridge
// Brief    : 16x-oversampled UART RX/TX with RX/TX FIFOs and a run-time
//            loopback / host / paced mode arbiter.
// Revision : 1.0
// ============================================================================
module uart_fifo_bridge
    import uart_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  tx,
    input  logic [1:0]            mode,
    input  logic                  pace_tick,
    uart_fifo_bridge_if.slave     host,
    output logic [ADDR_WIDTH:0]   rx_count,
    output logic [ADDR_WIDTH:0]   tx_count,
    output logic                  tx_busy,
    output logic                  rx_overflow,
    output logic                  frame_err,
    input  logic                  clr_err
);
    localparam int unsigned c_div   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned c_div_w = (c_div > 1) ? $clog2(c_div) : 1;
    localparam int unsigned c_os_w  = $clog2(OVERSAMPLE);
    localparam int unsigned c_bit_w = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);
    localparam logic [c_os_w-1:0]  c_os_half  = c_os_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_os_w-1:0]  c_os_last  = c_os_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_WIDTH - 1);

    logic [c_div_w-1:0]    r_div_cnt;
    logic                  w_tick;
    logic [1:0]            r_mode;
    logic                  r_pace;
    logic                  r_rx_meta, r_rx_sync;
    logic                  r_rx_overflow, r_frame_err;
    logic                  r_tx;

    rx_state_t             r_rx_state, w_rx_state_nxt;
    logic [c_os_w-1:0]     r_rx_os, w_rx_os_nxt;
    logic [c_bit_w-1:0]    r_rx_bit, w_rx_bit_nxt;
    logic [DATA_WIDTH-1:0] r_rx_shift, w_rx_shift_nxt;
    logic                  w_rx_push, w_rx_ferr;

    tx_state_t             r_tx_state, w_tx_state_nxt;
    logic [c_os_w-1:0]     r_tx_os, w_tx_os_nxt;
    logic [c_bit_w-1:0]    r_tx_bit, w_tx_bit_nxt;
    logic [DATA_WIDTH-1:0] r_tx_shift, w_tx_shift_nxt;
    logic                  w_tx_nxt;

    logic                  w_host_mode, w_start_ok, w_loop_xfer;
    logic                  w_wready, w_rvalid;
    logic                  w_rx_pop, w_rx_full, w_rx_empty;
    logic                  w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic [DATA_WIDTH-1:0] w_rx_head, w_tx_head, w_tx_wdata;

    assign w_tick = (r_div_cnt == c_div_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_mode    <= MODE_LOOP;
            r_pace    <= 1'b0;
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            r_mode    <= mode;
            r_pace    <= pace_tick;
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Mode 11 behaves as host; only paced mode gates frame starts.
    assign w_host_mode = (r_mode != MODE_LOOP);
    assign w_start_ok  = (r_mode == MODE_PACED) ? r_pace : 1'b1;
    assign w_loop_xfer = !w_host_mode && !w_rx_empty && !w_tx_full;
    assign w_wready    = w_host_mode && !w_tx_full;
    assign w_rvalid    = w_host_mode && !w_rx_empty;
    assign host.wready = w_wready;
    assign host.rvalid = w_rvalid;
    assign host.rdata  = w_rvalid ? w_rx_head : '0;
    assign w_rx_pop    = w_loop_xfer || (w_rvalid && host.rready);
    assign w_tx_push   = w_loop_xfer || (w_wready && host.wvalid);
    assign w_tx_wdata  = w_loop_xfer ? w_rx_head : host.wdata;

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .we(w_rx_push), .wdata(r_rx_shift), .re(w_rx_pop),
        .rdata(w_rx_head), .full(w_rx_full), .empty(w_rx_empty), .count(rx_count)
    );

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .we(w_tx_push), .wdata(w_tx_wdata), .re(w_tx_pop),
        .rdata(w_tx_head), .full(w_tx_full), .empty(w_tx_empty), .count(tx_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_os    <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_os    <= w_rx_os_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_os_nxt    = r_rx_os;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_push      = 1'b0;
        w_rx_ferr      = 1'b0;
        if (w_tick) begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_sync) begin
                        w_rx_state_nxt = RX_START;
                        w_rx_os_nxt    = '0;
                    end
                end
                RX_START: begin
                    if (r_rx_os == c_os_half) begin
                        // A start bit that is high again at mid-bit was a glitch.
                        w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
                        w_rx_os_nxt    = '0;
                        w_rx_bit_nxt   = '0;
                    end else begin
                        w_rx_os_nxt = r_rx_os + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_os == c_os_last) begin
                        w_rx_os_nxt    = '0;
                        w_rx_shift_nxt = {r_rx_sync, r_rx_shift[DATA_WIDTH-1:1]};
                        if (r_rx_bit == c_bit_last) w_rx_state_nxt = RX_STOP;
                        else                        w_rx_bit_nxt   = r_rx_bit + 1'b1;
                    end else begin
                        w_rx_os_nxt = r_rx_os + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_os == c_os_last) begin
                        w_rx_state_nxt = RX_IDLE;
                        w_rx_os_nxt    = '0;
                        w_rx_push      = r_rx_sync;
                        w_rx_ferr      = !r_rx_sync;
                    end else begin
                        w_rx_os_nxt = r_rx_os + 1'b1;
                    end
                end
                default: w_rx_state_nxt = RX_IDLE;
            endcase
        end
    end

    // A set event wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_overflow <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            if (w_rx_push && w_rx_full) r_rx_overflow <= 1'b1;
            else if (clr_err)           r_rx_overflow <= 1'b0;
            if (w_rx_ferr)              r_frame_err   <= 1'b1;
            else if (clr_err)           r_frame_err   <= 1'b0;
        end
    end

    assign rx_overflow = r_rx_overflow;
    assign frame_err   = r_frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_os    <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_os    <= w_tx_os_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_os_nxt    = r_tx_os;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_pop       = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_start_ok && !w_tx_empty) begin
                    w_tx_pop       = 1'b1;
                    w_tx_shift_nxt = w_tx_head;
                    w_tx_os_nxt    = '0;
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (w_tick) begin
                    if (r_tx_os == c_os_last) begin
                        w_tx_os_nxt    = '0;
                        w_tx_state_nxt = TX_DATA;
                    end else begin
                        w_tx_os_nxt = r_tx_os + 1'b1;
                    end
                end
            end
            TX_DATA: begin
                if (w_tick) begin
                    if (r_tx_os == c_os_last) begin
                        w_tx_os_nxt    = '0;
                        w_tx_shift_nxt = {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
                        if (r_tx_bit == c_bit_last) w_tx_state_nxt = TX_STOP;
                        else                        w_tx_bit_nxt   = r_tx_bit + 1'b1;
                    end else begin
                        w_tx_os_nxt = r_tx_os + 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (w_tick) begin
                    if (r_tx_os == c_os_last) begin
                        w_tx_os_nxt    = '0;
                        w_tx_state_nxt = TX_IDLE;
                    end else begin
                        w_tx_os_nxt = r_tx_os + 1'b1;
                    end
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
        // Line level is registered from the next state so tx never glitches.
        case (w_tx_state_nxt)
            TX_START: w_tx_nxt = 1'b0;
            TX_DATA:  w_tx_nxt = w_tx_shift_nxt[0];
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    assign tx      = r_tx;
    assign tx_busy = (r_tx_state != TX_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo_bridge
// Brief    : Self-checking bench for uart_fifo_bridge with queue reference model.
// Revision : 1.0
// ============================================================================
module tb_uart_fifo_bridge;
    import uart_fifo_pkg::*;

    localparam int unsigned c_dw      = 8;
    localparam int unsigned c_aw      = 2;
    localparam int unsigned c_depth   = 4;
    localparam int          c_bit_clk = 160;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic            rx        = 1'b1;
    logic            pace_tick = 1'b0;
    logic            clr_err   = 1'b0;
    logic [1:0]      mode      = MODE_HOST;
    logic            tx, tx_busy, rx_overflow, frame_err;
    logic [c_aw:0]   rx_count, tx_count;

    uart_fifo_bridge_if #(.DATA_WIDTH(c_dw)) host_if ();

    uart_fifo_bridge #(
        .DATA_WIDTH(c_dw), .ADDR_WIDTH(c_aw), .CLK_HZ(1600000), .BAUD(10000), .OVERSAMPLE(16)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .mode(mode), .pace_tick(pace_tick),
        .host(host_if), .rx_count(rx_count), .tx_count(tx_count), .tx_busy(tx_busy),
        .rx_overflow(rx_overflow), .frame_err(frame_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic [9:0] tx_q[$];
    logic       exp_ovf  = 1'b0;
    logic       saw_rvalid, saw_tx_low;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Line decoder: each captured frame is {busy throughout, stop bit, payload}.
    initial begin : tx_monitor
        logic [7:0] b;
        logic       busy_all;
        forever begin
            @(negedge tx);
            repeat (c_bit_clk / 2) @(negedge clk);
            busy_all = tx_busy;
            if (!tx) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (c_bit_clk) @(negedge clk);
                    b[i]     = tx;
                    busy_all = busy_all & tx_busy;
                end
                repeat (c_bit_clk) @(negedge clk);
                busy_all = busy_all & tx_busy;
                tx_q.push_back({busy_all, tx, b});
            end
        end
    end

    initial begin : watchdog
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (host_if.rvalid) saw_rvalid = 1'b1;
            if (!tx)            saw_tx_low = 1'b1;
        end
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode = m;
        step(2);
    endtask

    // Reference rule: good frames land in the RX queue (or go straight to TX
    // in loopback); a full RX queue drops the byte and raises overflow.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            step(c_bit_clk);
        end
        rx = 1'b1;
        if (stop_bit) begin
            if (mode == MODE_LOOP)            exp_tx.push_back(b);
            else if (exp_rx.size() < c_depth) exp_rx.push_back(b);
            else                              exp_ovf = 1'b1;
        end
    endtask

    task automatic host_write(input logic [7:0] b);
        int n;
        n = 0;
        host_if.wdata  = b;
        host_if.wvalid = 1'b1;
        while (!host_if.wready && n < 5000) begin
            step(1);
            n++;
        end
        if (n >= 5000) check_value("wready_timeout", host_if.wready, 1);
        step(1);
        host_if.wvalid = 1'b0;
        exp_tx.push_back(b);
    endtask

    task automatic host_read();
        logic [7:0] e;
        e = exp_rx.pop_front();
        check_value("rvalid", host_if.rvalid, 1);
        check_value("rdata", host_if.rdata, e);
        host_if.rready = 1'b1;
        step(1);
        host_if.rready = 1'b0;
    endtask

    task automatic expect_tx(input string tag);
        int n;
        int want;
        n    = 0;
        want = exp_tx.size();
        while (tx_q.size() < want && n < want * 2000 + 2000) begin
            step(1);
            n++;
        end
        check_value({tag, "_frames"}, tx_q.size(), want);
        while (exp_tx.size() > 0 && tx_q.size() > 0)
            check_value(tag, tx_q.pop_front(), {2'b11, exp_tx.pop_front()});
        exp_tx.delete();
        tx_q.delete();
        step(200);
    endtask

    initial begin : main
        logic [7:0] b;
        int         n;
        host_if.wdata  = '0;
        host_if.wvalid = 1'b0;
        host_if.rready = 1'b0;
        saw_rvalid     = 1'b0;
        saw_tx_low     = 1'b0;
        step(5);
        check_value("rst_tx", tx, 1);
        check_value("rst_tx_busy", tx_busy, 0);
        check_value("rst_rx_count", rx_count, 0);
        check_value("rst_tx_count", tx_count, 0);
        check_value("rst_rvalid", host_if.rvalid, 0);
        check_value("rst_rdata", host_if.rdata, 0);
        check_value("rst_overflow", rx_overflow, 0);
        check_value("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        set_mode(MODE_HOST);

        // Host receive: one byte at a time, popped by the host.
        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? 8'hA5 : 8'($urandom);
            send_rx(b, 1'b1);
            step(2);
            check_value("host_rx_count", rx_count, exp_rx.size());
            host_read();
            check_value("host_rx_rvalid_after_pop", host_if.rvalid, 0);
            check_value("host_rx_count_after_pop", rx_count, 0);
        end

        // Host transmit: back-to-back writes including the two fixed bytes.
        host_write(8'h3C);
        host_write(8'h81);
        for (int i = 0; i < 3; i++) host_write(8'($urandom));
        check_value("host_tx_busy", tx_busy, 1);
        expect_tx("host_tx");

        // Loopback: received bytes reappear on tx; host side stays silent.
        set_mode(MODE_LOOP);
        saw_rvalid = 1'b0;
        send_rx(8'h01, 1'b1);
        send_rx(8'h02, 1'b1);
        send_rx(8'h03, 1'b1);
        for (int i = 0; i < 2; i++) send_rx(8'($urandom), 1'b1);
        expect_tx("loop_tx");
        check_value("loop_rvalid_quiet", saw_rvalid, 0);

        // Paced: nothing leaves without pace_tick; one tick, one frame.
        set_mode(MODE_PACED);
        host_write(8'($urandom));
        host_write(8'($urandom));
        saw_tx_low = 1'b0;
        step(5000);
        check_value("paced_idle_line", saw_tx_low, 0);
        check_value("paced_tx_count", tx_count, 2);
        pace_tick = 1'b1;
        step(1);
        pace_tick = 1'b0;
        n = 0;
        while (!tx_busy && n < 20) begin
            step(1);
            n++;
        end
        check_value("paced_start", tx_busy, 1);
        step(800);
        pace_tick = 1'b1;
        step(1);
        pace_tick = 1'b0;
        n = 0;
        while (tx_busy && n < 2000) begin
            step(1);
            n++;
        end
        step(3000);
        check_value("paced_one_frame", tx_q.size(), 1);
        check_value("paced_tx_count_after", tx_count, 1);
        if (tx_q.size() > 0)
            check_value("paced_frame1", tx_q.pop_front(), {2'b11, exp_tx.pop_front()});
        pace_tick = 1'b1;
        step(1);
        pace_tick = 1'b0;
        expect_tx("paced_frame2");
        check_value("paced_tx_count_empty", tx_count, 0);

        // Overflow: host never reads while five frames arrive.
        set_mode(MODE_HOST);
        for (int i = 0; i < 5; i++) begin
            send_rx(8'($urandom), 1'b1);
            if (i == 3) check_value("ovf_not_yet", rx_overflow, 0);
        end
        step(2);
        check_value("ovf_rx_count", rx_count, exp_rx.size());
        check_value("ovf_flag", rx_overflow, exp_ovf);
        while (exp_rx.size() > 0) host_read();
        check_value("ovf_drained", rx_count, 0);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        exp_ovf = 1'b0;
        check_value("ovf_cleared", rx_overflow, exp_ovf);

        // Framing error: bad stop bit discards the byte; receiver recovers.
        check_value("ferr_clean", frame_err, 0);
        send_rx(8'($urandom), 1'b0);
        step(300);
        check_value("ferr_set", frame_err, 1);
        check_value("ferr_rx_count", rx_count, 0);
        send_rx(8'($urandom), 1'b1);
        step(2);
        host_read();
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check_value("ferr_cleared", frame_err, 0);

        // Asynchronous reset in the middle of a transmitted frame.
        host_write(8'($urandom));
        host_write(8'($urandom));
        step(500);
        check_value("mid_frame_busy", tx_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check_value("abort_tx", tx, 1);
        check_value("abort_tx_busy", tx_busy, 0);
        check_value("abort_tx_count", tx_count, 0);
        step(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
- Parametrised UART endpoint with its own 16x-oversampled receiver and transmitter, an RX FIFO, a TX FIFO and a mode arbiter.
- Generalises the earlier fixed 8-bit echo/send bridge: configurable data width, FIFO depth, baud, a selectable run-time mode (loopback / host / tick-paced), valid-ready host ports, fill counts and sticky error flags.
- Sits between the board pins and the application logic (e.g. clock/stopwatch display senders).

Parameters:
- DATA_WIDTH, 8, bits per UART frame payload and per FIFO word.
- ADDR_WIDTH, 4, FIFO depth = 2**ADDR_WIDTH per direction.
- CLK_HZ, 100000000, clk frequency.
- BAUD, 9600, line rate.
- OVERSAMPLE, 16, sample ticks per bit; divisor DIV = CLK_HZ/(BAUD*OVERSAMPLE), truncated, must be >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- rx  in  1  serial input, asynchronous to clk
- tx  out  1  serial output, idle high
- mode  in  2  00 loopback, 01 host, 10 paced, 11 treated as host
- pace_tick  in  1  one-cycle pulse gating TX frame starts in paced mode
- wdata  in  DATA_WIDTH  host byte to transmit
- wvalid  in  1  host write request
- wready  out  1  = !tx_full and mode != 00
- rdata  out  DATA_WIDTH  RX FIFO head; 0 when rvalid=0
- rvalid  out  1  = !rx_empty and mode != 00
- rready  in  1  host read accept
- rx_count  out  ADDR_WIDTH+1  RX FIFO fill
- tx_count  out  ADDR_WIDTH+1  TX FIFO fill
- tx_busy  out  1  frame on line
- rx_overflow  out  1  sticky: received byte dropped because RX FIFO full
- frame_err  out  1  sticky: stop bit sampled low
- clr_err  in  1  clears both sticky flags

Behaviour:
- Reset values: tx=1, tx_busy=0, counts=0, rvalid=0, rdata=0, flags=0, FIFOs empty, RX/TX FSMs IDLE, divisor counter 0.
- Baud tick: free-running counter 0..DIV-1 that pulses once per DIV clocks; shared by RX and TX.
- FIFO (first-word fall-through):
  - push when we & !full; push while full is dropped, even if a pop occurs in the same cycle.
  - pop when re & !empty; pop while empty is ignored.
  - push+pop in the same cycle, not full/empty: count unchanged.
  - Pointers wrap modulo depth; full = count==depth.
- RX FSM IDLE/START/DATA/STOP:
  - rx is double-flop synchronised.
  - IDLE->START on synchronised low.
  - START re-checks the line at sample OVERSAMPLE/2-1; if high it is a glitch and returns to IDLE.
  - DATA takes DATA_WIDTH bits LSB first, each sampled at mid-bit.
  - STOP samples mid-bit:
    - high: push the byte; if RX FIFO full, drop it and set rx_overflow.
    - low: discard the byte, set frame_err.
  - Returns to IDLE right after the stop sample.
- TX FSM IDLE/START/DATA/STOP:
  - Leaves IDLE when a start is permitted and the TX FIFO is non-empty; pops the head into the shift register in that cycle.
  - Start bit 0, then DATA_WIDTH bits LSB first, then stop bit 1; each bit lasts OVERSAMPLE baud ticks.
  - tx_busy is high from leaving IDLE until the stop bit ends.
- Start permission by mode:
  - Loopback and host: always.
  - Paced: only in the cycle after a pace_tick. pace_tick while busy or empty is discarded, not queued.
- Mode 00 (loopback): transfer RX head to TX FIFO each cycle while !rx_empty & !tx_full. Host ports are inactive: wready=0, rvalid=0, host pushes/pops ignored.
- Modes 01/10/11:
  - Host push on wvalid&wready.
  - Host pop on rvalid&rready.
  - Loopback transfer disabled.
- Mode change takes effect the next cycle. Frames in flight complete; FIFO contents are preserved.
- Sticky flags: a set event and clr_err in the same cycle leaves the flag set.
- Reset mid-frame: immediate abort, tx=1, FIFO contents lost.

Decomposition:
- Package uart_fifo_pkg:
  - mode encodings MODE_LOOP/MODE_HOST/MODE_PACED.
  - FSM state enums for RX and TX.
  - function computing DIV.
- Sub-module sync_fifo (DATA_WIDTH, ADDR_WIDTH; FWFT, count output), instantiated twice.
- RX/TX FSMs stay inline.

Test Plan (CLK_HZ=1600000, BAUD=10000, OVERSAMPLE=16 -> DIV=10, 160 clk/bit):
- Host mode, drive rx frame 0xA5 -> rvalid rises after the stop sample, rdata=0xA5, rx_count=1; rready pop -> rvalid=0, rx_count=0.
- Host mode, write 0x3C,0x81 back-to-back -> tx waveform: 0,0,0,1,1,1,1,0,0,1 then 0,1,0,0,0,0,0,0,1,1. Bits of 1600 clk per frame, tx_busy high throughout.
- Loopback, send 3 bytes 0x01,0x02,0x03 on rx -> same bytes emitted on tx in order; rvalid stays 0.
- Paced, preload 2 bytes, no pace_tick for 5000 clk -> tx stays 1. One pace_tick -> exactly one frame. pace_tick during that frame -> ignored.
- ADDR_WIDTH=2, host never reads, 5 rx frames -> rx_count=4, rx_overflow=1, first 4 bytes readable intact. clr_err -> rx_overflow=0.
- rx frame with stop bit 0 -> frame_err=1, rx_count unchanged. Assert rst mid-TX-frame -> tx=1, tx_busy=0, tx_count=0 immediately.
